// File: rtl/shift_pipe.sv
// Two-stage pipelined shift/rotate unit: S1 holds the decoded op, S2 holds the
// registered result, zero flag and tag. Valid/ready on both sides, with a flush.
module shift_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Logarithmic left barrel: rot selects wrap-around versus zero fill.
    function automatic logic [15:0] barrel_left(input logic [15:0] d, input logic [3:0] n,
                                                input logic rot);
        logic [15:0] v;
        v = d;
        v = n[0] ? (rot ? {v[14:0], v[15]}    : {v[14:0], 1'b0})  : v;
        v = n[1] ? (rot ? {v[13:0], v[15:14]} : {v[13:0], 2'b00}) : v;
        v = n[2] ? (rot ? {v[11:0], v[15:12]} : {v[11:0], 4'h0})  : v;
        v = n[3] ? (rot ? {v[7:0],  v[15:8]}  : {v[7:0],  8'h00}) : v;
        return v;
    endfunction

    function automatic logic [15:0] barrel_right(input logic [15:0] d, input logic [3:0] n,
                                                 input logic rot);
        logic [15:0] v;
        v = d;
        v = n[0] ? (rot ? {v[0],    v[15:1]} : {1'b0,  v[15:1]}) : v;
        v = n[1] ? (rot ? {v[1:0],  v[15:2]} : {2'b00, v[15:2]}) : v;
        v = n[2] ? (rot ? {v[3:0],  v[15:4]} : {4'h0,  v[15:4]}) : v;
        v = n[3] ? (rot ? {v[7:0],  v[15:8]} : {8'h00, v[15:8]}) : v;
        return v;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [3:0]       s1_amt_q,   s1_amt_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_zero_q,  out_zero_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic             s2_free_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic [WIDTH-1:0] result_s;

    // Handshake terms; in_ready is independent of in_valid.
    always_comb begin
        s2_free_s  = !out_valid_q || out_ready;
        s1_adv_s   = s1_valid_q && s2_free_s;
        in_ready_s = (!s1_valid_q || s2_free_s) && !flush;
        in_xfer_s  = in_valid && in_ready_s;
    end

    // Shift datapath between S1 and S2.
    always_comb begin
        case (s1_op_q)
            OP_ROL:  result_s = barrel_left(s1_data_q, s1_amt_q, 1'b1);
            OP_SLL:  result_s = barrel_left(s1_data_q, s1_amt_q, 1'b0);
            OP_ROR:  result_s = barrel_right(s1_data_q, s1_amt_q, 1'b1);
            OP_SRL:  result_s = barrel_right(s1_data_q, s1_amt_q, 1'b0);
            default: result_s = s1_data_q;
        endcase
    end

    // Next-state for both stages; payload registers only move on a transfer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_data_d   = s1_data_q;
        s1_amt_d    = s1_amt_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (in_xfer_s) begin
                s1_valid_d = 1'b1;
                s1_op_d    = in_op;
                s1_data_d  = in_data;
                s1_amt_d   = in_amt;
                s1_tag_d   = in_tag;
            end else if (s1_adv_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (s1_adv_s) begin
                out_valid_d = 1'b1;
                out_data_d  = result_s;
                out_zero_d  = (result_s == 16'h0000);
                out_tag_d   = s1_tag_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Pipeline registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_data_q   <= '0;
            s1_amt_q    <= 4'h0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            s1_amt_q    <= s1_amt_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed scenarios plus a randomized op/amount sweep,
// scored against an arithmetic reference model and an in-flight queue.
module tb_shift_pipe;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [1:0]       in_op;
    logic [15:0]      in_data, out_data;
    logic [3:0]       in_amt;
    logic [TAG_W-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(16), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .in_amt(in_amt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        int               acc;
    } ent_t;

    ent_t             q[$];
    logic [15:0]      obs_d[$];
    logic             obs_z[$];
    logic [TAG_W-1:0] obs_t[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    bit               accepted = 1'b0;
    bit               stalled = 1'b0;
    logic [15:0]      st_data;
    logic [TAG_W-1:0] st_tag;
    logic             st_zero;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                              input logic [3:0] a);
        int unsigned x, n, r;
        x = 32'(d);
        n = 32'(a);
        case (op)
            2'b00:   r = (n == 0) ? x : ((x << n) | (x >> (16 - n)));
            2'b01:   r = x << n;
            2'b10:   r = (n == 0) ? x : ((x >> n) | (x << (16 - n)));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    // One clock: check pre-edge outputs against the model, update it, advance.
    task automatic tick();
        ent_t e;
        logic exp_ov;
        #1;
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 1);
        chk("in_ready", 32'(in_ready), 32'(!flush && (q.size() < 2 || out_ready)));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (stalled) begin
            chk("stall_data", 32'(out_data), 32'(st_data));
            chk("stall_tag", 32'(out_tag), 32'(st_tag));
            chk("stall_zero", 32'(out_zero), 32'(st_zero));
        end
        if (out_valid) chk("zero_flag", 32'(out_zero), 32'(out_data == 16'h0000));
        accepted = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("res_data", 32'(out_data), 32'(e.data));
                    chk("res_tag", 32'(out_tag), 32'(e.tag));
                end else begin
                    chk("spurious_out", 32'(out_valid), 32'(1'b0));
                end
                obs_d.push_back(out_data);
                obs_z.push_back(out_zero);
                obs_t.push_back(out_tag);
            end
            if (in_valid && in_ready) begin
                e.data = ref_shift(in_op, in_data, in_amt);
                e.tag  = in_tag;
                e.acc  = cyc + 1;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        stalled = out_valid && !out_ready && !rst && !flush;
        st_data = out_data;
        st_tag  = out_tag;
        st_zero = out_zero;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a,
                          input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
    endtask

    initial begin
        logic [15:0] stream_exp [5];
        int guard;
        stream_exp[0] = 16'h0FF0; stream_exp[1] = 16'h8000; stream_exp[2] = 16'h0001;
        stream_exp[3] = 16'h1234; stream_exp[4] = 16'h0000;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_data = 16'h0; in_amt = 4'h0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_zero", 32'(out_zero), 32'(1'b0));
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'(1'b1));

        // Basic latency
        set_op(2'b00, 16'h8001, 4'd1, 3'd5);
        tick();
        in_valid = 1'b0;
        tick();
        chk("lat_valid", 32'(out_valid), 32'(1'b1));
        chk("lat_data", 32'(out_data), 32'h0003);
        chk("lat_zero", 32'(out_zero), 32'(1'b0));
        chk("lat_tag", 32'(out_tag), 32'd5);
        tick();
        chk("lat_one_cycle", 32'(out_valid), 32'(1'b0));

        // Back-to-back stream
        obs_d.delete(); obs_z.delete(); obs_t.delete();
        set_op(2'b01, 16'h00FF, 4'd4, 3'd0);  tick();
        set_op(2'b10, 16'h0001, 4'd1, 3'd1);  tick();
        set_op(2'b11, 16'h8000, 4'd15, 3'd2); tick();
        set_op(2'b01, 16'h1234, 4'd0, 3'd3);  tick();
        set_op(2'b11, 16'h00F0, 4'd8, 3'd4);  tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_count", 32'(obs_d.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_d.size(); i++) begin
            chk($sformatf("stream_data%0d", i), 32'(obs_d[i]), 32'(stream_exp[i]));
            chk($sformatf("stream_zero%0d", i), 32'(obs_z[i]), 32'(i == 4));
        end

        // Backpressure
        obs_d.delete(); obs_z.delete(); obs_t.delete();
        out_ready = 1'b0;
        set_op(2'b01, 16'h0003, 4'd2, 3'd1); tick();
        set_op(2'b11, 16'hFFFF, 4'd4, 3'd2); tick();
        set_op(2'b00, 16'h1234, 4'd4, 3'd3);
        chk("bp_ready_low", 32'(in_ready), 32'(1'b0));
        tick();
        chk("bp_not_accepted", 32'(accepted), 32'(1'b0));
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_release_accept", 32'(accepted), 32'(1'b1));
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", 32'(obs_d.size()), 32'd3);
        if (obs_d.size() == 3) begin
            chk("bp_res0", 32'(obs_d[0]), 32'h000C);
            chk("bp_res1", 32'(obs_d[1]), 32'h0FFF);
            chk("bp_res2", 32'(obs_d[2]), 32'h2341);
        end

        // Flush while full and stalled
        obs_d.delete(); obs_z.delete(); obs_t.delete();
        out_ready = 1'b0;
        set_op(2'b01, 16'h0101, 4'd1, 3'd1); tick();
        set_op(2'b01, 16'h0202, 4'd1, 3'd2); tick();
        set_op(2'b01, 16'h0303, 4'd1, 3'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'(1'b0));
        tick();
        chk("flush_s1_empty", 32'(out_valid), 32'(1'b0));
        out_ready = 1'b1;
        set_op(2'b10, 16'hF000, 4'd4, 3'd6); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("flush_count", 32'(obs_d.size()), 32'd1);
        if (obs_d.size() == 1) begin
            chk("flush_ror_data", 32'(obs_d[0]), 32'h0F00);
            chk("flush_ror_tag", 32'(obs_t[0]), 32'd6);
        end

        // Reset mid-stream with both stages full and stalled
        out_ready = 1'b0;
        set_op(2'b00, 16'hABCD, 4'd3, 3'd7); tick();
        set_op(2'b11, 16'hABCD, 4'd3, 3'd4); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("mrst_out_data", 32'(out_data), 32'h0);
        chk("mrst_out_tag", 32'(out_tag), 32'h0);
        chk("mrst_in_ready", 32'(in_ready), 32'(1'b1));
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomized sweep over every op and amount
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                set_op(2'(op), 16'($urandom), 4'(a), 3'($urandom_range(0, 7)));
                guard = 0;
                do begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                end while (!accepted && guard < 50);
                chk("sweep_accept", 32'(accepted), 32'(1'b1));
                in_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("sweep_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Two-stage pipelined shift/rotate execution unit for the WISC execute path.
- Takes decoded shift operations from decode, produces registered results and a zero flag for writeback.
- Left shifts use the team's 16-bit logarithmic left barrel; right shifts and rotates use a matching right path.
- Valid/ready handshakes on both sides, plus a flush for branch mispredict.

Parameters:
- WIDTH, 16, data width; fixed at 16 for the ISA, and no other value is supported.
- TAG_W, 3, width of the destination-register tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operation offered by decode
- in_ready  output  1  unit accepts the offered operation this cycle
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- in_data  input  16  operand
- in_amt  input  4  shift amount 0..15
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result available
- out_ready  input  1  writeback consumes the result this cycle
- out_data  output  16  result
- out_zero  output  1  out_data == 0
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Stage S1 registers: s1_valid, op, data, amt, tag. Stage S2 registers: out_valid, out_data, out_zero, out_tag.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Stage advance: s2_free = !out_valid | out_ready. s1_adv = s1_valid & s2_free.
- in_ready = (!s1_valid | s2_free) & !flush. in_ready is combinational and must not depend on in_valid.
- Latency: 2 cycles with out_ready held high. An op accepted at edge N appears with out_valid=1 after edge N+1 and is consumed at edge N+2 if out_ready.
- Throughput: one op per cycle with no backpressure. No bubbles are inserted when both stages drain simultaneously.
- Stall: with out_valid=1 and out_ready=0, S2 holds data, tag and zero stable. S1 holds once full, and in_ready drops. No value is lost or duplicated.
- Shift arithmetic, computed combinationally between S1 and S2 on the S1 registers (n = amt):
  - SLL: data << n, zero fill.
  - SRL: data >> n, zero fill.
  - ROL: (data << n) | (data >> (16-n)).
  - ROR: (data >> n) | (data << (16-n)).
  - For n=0 every op passes data unchanged. The rotate complement term is defined as 0 when n=0, so no 16-bit shift is performed.
- out_zero is computed from the same result and registered in S2 with it.
- Flush:
  - Clears s1_valid and out_valid at the next edge, regardless of out_ready.
  - Any input offered the same cycle is not accepted, because in_ready=0.
  - Data and tag registers need not be cleared.
- Reset (priority over flush and all transfers): s1_valid=0, out_valid=0, out_data=0, out_zero=0, out_tag=0. in_ready=1 in the first cycle after reset with flush low.
- Reset or flush mid-stall: pending results are discarded and are never presented.
- Simultaneous output transfer and new input with both stages full: S2 loads S1's result, S1 loads the new op, and everything advances in the same edge.
- Data and tag registers load only on their stage's advance or input transfer, so they hold while stalled.

Test Plan:
- Basic latency: after reset, offer ROL data=0x8001 amt=1 tag=5 with out_ready=1 -> two edges later out_valid=1, out_data=0x0003, out_zero=0, out_tag=5, valid for exactly one cycle.
- Back-to-back stream, out_ready=1: SLL 0x00FF/4, ROR 0x0001/1, SRL 0x8000/15, SLL 0x1234/0, SRL 0x00F0/8 on consecutive cycles -> consecutive results 0x0FF0, 0x8000, 0x0001, 0x1234, 0x0000 (out_zero=1 only on the last), in_ready constantly 1.
- Backpressure: hold out_ready=0 while offering 3 ops -> two accepted, in_ready=0 thereafter, out_data stable. Then release out_ready -> results in order, third op accepted on the release cycle, no loss or duplication.
- Flush while full and stalled -> out_valid=0 and s1 empty next cycle. A following ROR 0xF000/4 -> 0x0F00 with the correct tag.
- Reset asserted mid-stream with out_ready=0 and both stages valid -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1. No stale result is ever emitted.
- Exhaustive sweep: random data, all ops × amt 0..15, random out_ready -> every result matches the reference model, in order, with the matching tag.
